// File: rtl/bpsk_pkg.sv
// Shared framing definitions for the BPSK transmit serializer and the receive-side deframer.
package bpsk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    DATA,
    TAIL
  } frame_state_t;

  localparam logic [7:0] PREAMBLE_PATTERN = 8'h55;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data and a registered occupancy count.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bpsk_frame_serializer.sv
// Buffers UART bytes and emits preamble, sync word, payload and tail as a fixed-rate
// LSB-first symbol stream for the BPSK modulator.
module bpsk_frame_serializer
  import bpsk_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 16,
  parameter int         SYMBOL_DIV     = 8,
  parameter int         PREAMBLE_BYTES = 2,
  parameter logic [7:0] SYNC_WORD      = 8'h7E,
  parameter int         TAIL_BITS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] word,
  input  logic       write,
  output logic       bit_out,
  output logic       bit_strobe,
  output logic       tx_active,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int TW = $clog2(SYMBOL_DIV);
  localparam int PW = $clog2(PREAMBLE_BYTES+1);
  localparam int KW = $clog2(TAIL_BITS+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  frame_state_t  state;
  frame_state_t  state_nxt;
  logic [TW-1:0] sym_cnt;
  logic          sym_end;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_nxt;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_cnt_nxt;
  logic [KW-1:0] tail_cnt;
  logic [KW-1:0] tail_cnt_nxt;
  logic          pop;
  logic [7:0]    fifo_data;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (write),
    .push_data(word),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign tx_active  = (state != IDLE);
  assign sym_end    = tx_active && (sym_cnt == TW'(SYMBOL_DIV-1));
  assign bit_strobe = tx_active && (sym_cnt == '0);
  // The shift register only advances at symbol boundaries, so bit_out changes on strobe cycles.
  assign bit_out    = tx_active && shreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt <= '0;
    end else if (state == IDLE || sym_end) begin
      sym_cnt <= '0;
    end else begin
      sym_cnt <= sym_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= write && fifo_full && !pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      pre_cnt  <= '0;
      tail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      pre_cnt  <= pre_cnt_nxt;
      tail_cnt <= tail_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    pre_cnt_nxt  = pre_cnt;
    tail_cnt_nxt = tail_cnt;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          state_nxt   = PREAMBLE;
          shreg_nxt   = PREAMBLE_PATTERN;
          bit_cnt_nxt = '0;
          pre_cnt_nxt = '0;
        end
      end

      PREAMBLE: begin
        if (sym_end) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (pre_cnt == PW'(PREAMBLE_BYTES-1)) begin
              state_nxt = SYNC;
              shreg_nxt = SYNC_WORD;
            end else begin
              pre_cnt_nxt = pre_cnt + 1'b1;
              shreg_nxt   = PREAMBLE_PATTERN;
            end
          end else begin
            shreg_nxt = {1'b0, shreg[7:1]};
          end
        end
      end

      // SYNC is only entered with a non-empty FIFO, so the first payload pop always succeeds.
      SYNC: begin
        if (sym_end) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            pop       = 1'b1;
            shreg_nxt = fifo_data;
            state_nxt = DATA;
          end else begin
            shreg_nxt = {1'b0, shreg[7:1]};
          end
        end
      end

      DATA: begin
        if (sym_end) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (!fifo_empty) begin
              pop       = 1'b1;
              shreg_nxt = fifo_data;
            end else begin
              state_nxt    = TAIL;
              shreg_nxt    = '0;
              tail_cnt_nxt = '0;
            end
          end else begin
            shreg_nxt = {1'b0, shreg[7:1]};
          end
        end
      end

      TAIL: begin
        if (sym_end) begin
          if (tail_cnt == KW'(TAIL_BITS-1)) begin
            state_nxt = IDLE;
          end else begin
            tail_cnt_nxt = tail_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
